// File: rtl/weight_buf_pkg.sv
// Shared types and helpers for the weight stream buffer: FSM encoding,
// read latency and the bank base-address layout.
package weight_buf_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } wsb_state_e;

  localparam int RD_LAT = 2;

  // Bank b occupies addresses b*rows .. b*rows+rows-1.
  function automatic int bank_base(input int bank, input int rows);
    return bank * rows;
  endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM with registered read data; storage is not reset, the
// output register is.
module single_port_ram #(
  parameter int DATA_WIDTH = 162,
  parameter int ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_W)-1];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= din;
    end
  end

  // Read data holds between reads so the consumer sees a stable word.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (en && !we) begin
      dout_q <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/wsb_addr_gen.sv
// Stream sequencer: walks rows with wrap-around, counts remaining rows and
// drains the read pipeline before returning to idle.
module wsb_addr_gen
  import weight_buf_pkg::*;
#(
  parameter int ROWS  = 42,
  parameter int ROW_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ROW_W-1:0] start_row,
  input  logic [ROW_W-1:0] num_rows,
  input  logic             adv,
  output logic             issue,
  output logic [ROW_W-1:0] row,
  output logic             last,
  output logic             busy
);

  wsb_state_e       state_q, state_d;
  logic [ROW_W-1:0] cur_q, cur_d;
  logic [ROW_W-1:0] remaining_q, remaining_d;
  logic [1:0]       drain_q, drain_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      remaining_q <= '0;
      drain_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    issue       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (num_rows != '0)) begin
          state_d     = S_STREAM;
          cur_d       = (32'(start_row) >= ROWS) ? '0 : start_row;
          remaining_d = num_rows;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (adv) begin
          issue       = 1'b1;
          cur_d       = (cur_q == ROW_W'(ROWS - 1)) ? '0 : cur_q + ROW_W'(1);
          remaining_d = remaining_q - ROW_W'(1);
          if (remaining_q == ROW_W'(1)) begin
            state_d = S_DRAIN;
            drain_d = 2'd0;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      // Hold busy until the last issued row has left the read pipeline.
      S_DRAIN: begin
        if (drain_q == 2'(RD_LAT - 1)) begin
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign row  = cur_q;
  assign last = (remaining_q == ROW_W'(1));
  assign busy = (state_q != S_IDLE);

endmodule

// File: rtl/weight_stream_buffer.sv
// Loadable multi-bank weight store feeding the MAC lanes one row per bank
// per cycle, via index reads or an autonomous wrapping stream.
module weight_stream_buffer
  import weight_buf_pkg::*;
#(
  parameter int ELEM_W    = 18,
  parameter int ELEMS     = 9,
  parameter int NUM_BANKS = 2,
  parameter int ROWS      = 42,
  parameter int ADDR_W    = 12,
  parameter int ROW_W     = 12,
  localparam int WORD_W   = ELEMS * ELEM_W,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_en,
  input  logic [ROW_W-1:0]            rd_row,
  input  logic                        start,
  input  logic [ROW_W-1:0]            start_row,
  input  logic [ROW_W-1:0]            num_rows,
  input  logic                        adv,
  input  logic                        ld_en,
  input  logic [BANK_W-1:0]           ld_bank,
  input  logic [ROW_W-1:0]            ld_row,
  input  logic [WORD_W-1:0]           ld_data,
  output logic [NUM_BANKS*WORD_W-1:0] q,
  output logic                        q_valid,
  output logic [ROW_W-1:0]            q_row,
  output logic                        busy,
  output logic                        done,
  output logic                        ld_err
);

  logic             gen_issue, gen_last, gen_busy, idle;
  logic [ROW_W-1:0] gen_row, rd_row_c;
  logic             rd_issue, ld_ok;

  logic              v1_q, v1_d, last1_q, last1_d, we1_q, we1_d;
  logic [ROW_W-1:0]  row1_q, row1_d;
  logic [BANK_W-1:0] wbank1_q, wbank1_d;
  logic [WORD_W-1:0] wdata1_q, wdata1_d;
  logic              v2_q, v2_d, done_q, done_d, ld_err_q, ld_err_d;
  logic [ROW_W-1:0]  q_row_q, q_row_d;

  wsb_addr_gen #(.ROWS(ROWS), .ROW_W(ROW_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .start_row(start_row),
    .num_rows (num_rows),
    .adv      (adv),
    .issue    (gen_issue),
    .row      (gen_row),
    .last     (gen_last),
    .busy     (gen_busy)
  );

  assign idle = !gen_busy;

  // Stage 1: choose one RAM operation (stream, index read or load) per cycle.
  always_comb begin
    rd_row_c = (32'(rd_row) >= ROWS) ? '0 : rd_row;
    rd_issue = idle && rd_en && !start;
    ld_ok    = ld_en && idle && !rd_en && !start &&
               (32'(ld_row) < ROWS) && (32'(ld_bank) < NUM_BANKS);
    v1_d     = gen_issue || rd_issue;
    last1_d  = gen_issue && gen_last;
    we1_d    = ld_ok;
    wbank1_d = ld_bank;
    wdata1_d = ld_data;
    ld_err_d = ld_en && !ld_ok;
    if (gen_issue) begin
      row1_d = gen_row;
    end else if (rd_issue) begin
      row1_d = rd_row_c;
    end else begin
      row1_d = ld_row;
    end
  end

  // Stage 2 tracks the RAM output register so q, q_valid and q_row align.
  always_comb begin
    v2_d    = v1_q;
    done_d  = v1_q && last1_q;
    if (v1_q) begin
      q_row_d = row1_q;
    end else begin
      q_row_d = q_row_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      we1_q    <= 1'b0;
      row1_q   <= '0;
      wbank1_q <= '0;
      wdata1_q <= '0;
      v2_q     <= 1'b0;
      done_q   <= 1'b0;
      q_row_q  <= '0;
      ld_err_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      last1_q  <= last1_d;
      we1_q    <= we1_d;
      row1_q   <= row1_d;
      wbank1_q <= wbank1_d;
      wdata1_q <= wdata1_d;
      v2_q     <= v2_d;
      done_q   <= done_d;
      q_row_q  <= q_row_d;
      ld_err_q <= ld_err_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [ADDR_W-1:0] addr;
    logic              en;
    assign addr = ADDR_W'(bank_base(b, ROWS)) + ADDR_W'(row1_q);
    assign en   = v1_q || (we1_q && (wbank1_q == BANK_W'(b)));

    single_port_ram #(.DATA_WIDTH(WORD_W), .ADDR_W(ADDR_W)) u_ram (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .we   (we1_q),
      .addr (addr),
      .din  (wdata1_q),
      .dout (q[b*WORD_W +: WORD_W])
    );
  end

  assign q_valid = v2_q;
  assign q_row   = q_row_q;
  assign done    = done_q;
  assign ld_err  = ld_err_q;
  assign busy    = gen_busy;

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Directed self-checking bench for weight_stream_buffer: index reads, wrapping
// and paused streams, load rejection, mid-stream reset and start corner cases.
module tb_weight_stream_buffer;

  localparam int W = 162;

  logic           clk = 1'b0;
  logic           reset, rd_en, start, adv, ld_en;
  logic [11:0]    rd_row, start_row, num_rows, ld_row;
  logic [0:0]     ld_bank;
  logic [W-1:0]   ld_data;
  logic [2*W-1:0] q;
  logic           q_valid, busy, done, ld_err;
  logic [11:0]    q_row;

  logic [W-1:0] exp_mem [2][42];
  int total = 0;
  int bad   = 0;

  weight_stream_buffer dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_row(rd_row),
    .start(start), .start_row(start_row), .num_rows(num_rows), .adv(adv),
    .ld_en(ld_en), .ld_bank(ld_bank), .ld_row(ld_row), .ld_data(ld_data),
    .q(q), .q_valid(q_valid), .q_row(q_row), .busy(busy), .done(done),
    .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pat(input int b, input int r, input int salt);
    logic [W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*18 +: 18] = 18'(b * 4096 + r * 64 + k + salt * 1000);
    return w;
  endfunction

  function automatic logic [2*W-1:0] exp_q(input int r);
    return {exp_mem[1][r], exp_mem[0][r]};
  endfunction

  task automatic load(input int b, input int r, input logic [W-1:0] d, output logic err);
    ld_en = 1'b1; ld_bank = 1'(b); ld_row = 12'(r); ld_data = d;
    tick();
    err = ld_err;
    ld_en = 1'b0;
    if (b < 2 && r < 42) exp_mem[b][r] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (q !== '0)        begin bad++; $display("FAIL reset_q got=%h exp=0", q); end
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
    total++; if (q_row !== 12'd0)  begin bad++; $display("FAIL reset_q_row got=%0d exp=0", q_row); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || ld_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags got busy=%b done=%b ld_err=%b exp=000", busy, done, ld_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_read();
    logic err;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 42; r++) load(b, r, pat(b, r, 0), err);
    load(0, 5, pat(0, 5, 7), err);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL load_a_err got=%b exp=0", err); end
    load(1, 5, pat(1, 5, 9), err);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL load_b_err got=%b exp=0", err); end
    rd_en = 1'b1; rd_row = 12'd5;
    tick();
    rd_en = 1'b0;
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL idx_early_valid got=%b exp=0", q_valid); end
    tick();
    total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL idx_valid got=%b exp=1", q_valid); end
    total++; if (q !== {pat(1, 5, 9), pat(0, 5, 7)}) begin
      bad++; $display("FAIL idx_data got=%h exp=%h", q, {pat(1, 5, 9), pat(0, 5, 7)});
    end
    total++; if (q_row !== 12'd5) begin bad++; $display("FAIL idx_row got=%0d exp=5", q_row); end
    tick();
    total++; if (q_valid !== 1'b0 || q !== exp_q(5)) begin
      bad++; $display("FAIL idx_hold got valid=%b q=%h exp valid=0 q=%h", q_valid, q, exp_q(5));
    end
  endtask

  task automatic test_stream_wrap();
    int rows [4] = '{40, 41, 0, 1};
    start = 1'b1; start_row = 12'd40; num_rows = 12'd4; adv = 1'b1;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrap_busy_start got=%b exp=1", busy); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (q_valid !== (k >= 2 && k <= 5)) begin
        bad++; $display("FAIL wrap_valid k=%0d got=%b exp=%b", k, q_valid, (k >= 2 && k <= 5));
      end
      if (k >= 2 && k <= 5) begin
        total++; if (q_row !== 12'(rows[k-2]) || q !== exp_q(rows[k-2])) begin
          bad++; $display("FAIL wrap_row k=%0d got=%0d exp=%0d", k, q_row, rows[k-2]);
        end
      end
      total++; if (done !== (k == 5)) begin bad++; $display("FAIL wrap_done k=%0d got=%b exp=%b", k, done, (k == 5)); end
      total++; if (busy !== (k <= 5)) begin bad++; $display("FAIL wrap_busy k=%0d got=%b exp=%b", k, busy, (k <= 5)); end
    end
  endtask

  task automatic test_adv_pause();
    logic advp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int nvalid = 0;
    start = 1'b1; start_row = 12'd10; num_rows = 12'd3; adv = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      adv = advp[k];
      tick();
      if (q_valid === 1'b1) nvalid++;
      total++; if (q_valid !== (k == 1 || k == 3 || k == 5)) begin
        bad++; $display("FAIL pause_valid k=%0d got=%b", k, q_valid);
      end
      if (k == 1 || k == 3 || k == 5) begin
        total++; if (q_row !== 12'(10 + (k - 1) / 2) || q !== exp_q(10 + (k - 1) / 2)) begin
          bad++; $display("FAIL pause_row k=%0d got=%0d exp=%0d", k, q_row, 10 + (k - 1) / 2);
        end
      end
      total++; if (done !== (k == 5)) begin bad++; $display("FAIL pause_done k=%0d got=%b exp=%b", k, done, (k == 5)); end
    end
    total++; if (nvalid != 3) begin bad++; $display("FAIL pause_count got=%0d exp=3", nvalid); end
    adv = 1'b0;
  endtask

  task automatic test_ld_err();
    start = 1'b1; start_row = 12'd0; num_rows = 12'd2; adv = 1'b1;
    tick();
    start = 1'b0;
    ld_en = 1'b1; ld_bank = 1'b0; ld_row = 12'd3; ld_data = pat(0, 3, 55);
    tick();
    ld_en = 1'b0;
    total++; if (ld_err !== 1'b1) begin bad++; $display("FAIL lderr_stream got=%b exp=1", ld_err); end
    tick();
    total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL lderr_clear got=%b exp=0", ld_err); end
    for (int k = 0; k < 5; k++) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lderr_stream_end got busy=%b exp=0", busy); end
    ld_en = 1'b1; ld_bank = 1'b0; ld_row = 12'd42; ld_data = pat(0, 0, 66);
    tick();
    ld_en = 1'b0;
    total++; if (ld_err !== 1'b1) begin bad++; $display("FAIL lderr_range got=%b exp=1", ld_err); end
    ld_en = 1'b1; ld_bank = 1'b0; ld_row = 12'd3; ld_data = pat(0, 3, 77);
    rd_en = 1'b1; rd_row = 12'd3;
    tick();
    ld_en = 1'b0; rd_en = 1'b0;
    total++; if (ld_err !== 1'b1) begin bad++; $display("FAIL lderr_collide got=%b exp=1", ld_err); end
    tick();
    total++; if (q_valid !== 1'b1 || q !== exp_q(3)) begin
      bad++; $display("FAIL lderr_readback3 got valid=%b q=%h exp q=%h", q_valid, q, exp_q(3));
    end
    rd_en = 1'b1; rd_row = 12'd0;
    tick();
    rd_en = 1'b0;
    tick();
    total++; if (q_valid !== 1'b1 || q !== exp_q(0)) begin
      bad++; $display("FAIL lderr_readback0 got valid=%b q=%h exp q=%h", q_valid, q, exp_q(0));
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; start_row = 12'd0; num_rows = 12'd10; adv = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (q_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rstmid k=%0d got valid=%b done=%b busy=%b exp=000", k, q_valid, done, busy);
      end
    end
    adv = 1'b0;
    rd_en = 1'b1; rd_row = 12'd7;
    tick();
    rd_en = 1'b0;
    tick();
    total++; if (q_valid !== 1'b1 || q_row !== 12'd7 || q !== exp_q(7)) begin
      bad++; $display("FAIL rstmid_read got valid=%b row=%0d exp valid=1 row=7", q_valid, q_row);
    end
  endtask

  task automatic test_start_zero();
    start = 1'b1; start_row = 12'd4; num_rows = 12'd0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (busy !== 1'b0 || q_valid !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL start0 k=%0d got busy=%b valid=%b done=%b exp=000", k, busy, q_valid, done);
      end
      tick();
    end
  endtask

  task automatic test_start_and_rd();
    start = 1'b1; start_row = 12'd20; num_rows = 12'd1; adv = 1'b1;
    rd_en = 1'b1; rd_row = 12'd3;
    tick();
    start = 1'b0; rd_en = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL both_busy got=%b exp=1", busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (q_valid !== (k == 2)) begin bad++; $display("FAIL both_valid k=%0d got=%b exp=%b", k, q_valid, (k == 2)); end
      if (k == 2) begin
        total++; if (q_row !== 12'd20 || q !== exp_q(20)) begin
          bad++; $display("FAIL both_row got=%0d exp=20", q_row);
        end
      end
      total++; if (done !== (k == 2)) begin bad++; $display("FAIL both_done k=%0d got=%b exp=%b", k, done, (k == 2)); end
      total++; if (busy !== (k <= 2)) begin bad++; $display("FAIL both_busyk k=%0d got=%b exp=%b", k, busy, (k <= 2)); end
    end
    adv = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0; start = 1'b0; adv = 1'b0; ld_en = 1'b0;
    rd_row = '0; start_row = '0; num_rows = '0; ld_row = '0; ld_bank = '0; ld_data = '0;
    test_reset();
    test_load_read();
    test_stream_wrap();
    test_adv_pause();
    test_ld_err();
    test_reset_mid();
    test_start_zero();
    test_start_and_rd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_stream_buffer.md
Name: weight_stream_buffer

Overview:
Parametrised, loadable weight store for the LSTM matrix-vector datapath. It generalises the fixed two-bank, 9-lane ROM buffer to NUM_BANKS banks of ELEMS lanes of ELEM_W bits each. It adds a runtime load port, a row-index read mode and an autonomous streaming mode with wrap-around and a valid/done handshake. It sits between the weight loader and the MAC lane arrays and delivers one row per bank per cycle.

Parameters:
ELEM_W, 18, bits per weight element
ELEMS, 9, elements packed per RAM word (lanes per bank)
NUM_BANKS, 2, parallel banks (output channels)
ROWS, 42, rows per bank; valid row range is 0..ROWS-1
ADDR_W, 12, RAM address width; require NUM_BANKS*ROWS <= 2^ADDR_W
ROW_W, 12, width of row index, start and count ports

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rd_en  in  1  index-mode read request (IDLE only)
rd_row  in  ROW_W  row for index-mode read
start  in  1  begin stream (IDLE only)
start_row  in  ROW_W  first streamed row
num_rows  in  ROW_W  rows to stream; 0 means no stream
adv  in  1  stream issue enable; low pauses issue
ld_en  in  1  write one word
ld_bank  in  clog2(NUM_BANKS) max 1  target bank
ld_row  in  ROW_W  target row
ld_data  in  ELEMS*ELEM_W  packed word; lane k at [k*ELEM_W +: ELEM_W]
q  out  NUM_BANKS*ELEMS*ELEM_W  bank b word at [b*ELEMS*ELEM_W +: ELEMS*ELEM_W]
q_valid  out  1  q holds a valid row
q_row  out  ROW_W  row index of the current q
busy  out  1  stream in progress, including drain
done  out  1  one-cycle pulse together with the last streamed q_valid
ld_err  out  1  one-cycle pulse when ld_en is rejected

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset.
- Storage: one single_port_ram per bank, DATA_WIDTH=ELEMS*ELEM_W, ADDR_W wide. Bank b row r lives at address b*ROWS + r, keeping the existing base-offset layout. RAM contents are not reset.
- Read latency is 2 cycles: request cycle, then address register, then RAM output register. q, q_valid and q_row update together. q holds its last value while q_valid=0.
- Index mode: rd_en in IDLE issues one read of rd_row on all banks. rd_en outside IDLE is ignored.
- Stream mode FSM with states IDLE, STREAM and DRAIN:
  - IDLE to STREAM on start with num_rows != 0. Latch cur=start_row and remaining=num_rows. busy=1 from the next cycle.
  - In STREAM, each cycle with adv=1 issues a read of cur, then sets cur = (cur==ROWS-1) ? 0 : cur+1 and decrements remaining. adv=0 issues nothing and holds state.
  - Issuing the last row moves the FSM to DRAIN. DRAIN waits 2 cycles, then returns to IDLE.
  - done pulses with the q_valid of the last row. busy falls the cycle after done.
  - start with num_rows==0 is a no-op, with no done pulse. start outside IDLE is ignored. start and rd_en together in IDLE: start wins.
- Load: ld_en is accepted only in IDLE with no rd_en or start that cycle. It writes ld_data to address ld_bank*ROWS + ld_row.
  - ld_en outside IDLE, or colliding with rd_en or start, is dropped and ld_err pulses the next cycle.
  - ld_row >= ROWS or ld_bank >= NUM_BANKS is dropped with ld_err.
- Out-of-range rd_row or start_row (>= ROWS) is clamped to 0. No error output.
- Reset values: q=0, q_valid=0, q_row=0, busy=0, done=0, ld_err=0, state IDLE.
- Reset asserted mid-stream returns the FSM to IDLE and kills in-flight valids. No done pulse is produced.

Decomposition:
- Shared package (weight_buf_pkg) holds:
  - FSM state encoding: IDLE=0, STREAM=1, DRAIN=2.
  - RD_LAT=2.
  - A function for bank base address, b*ROWS.
- Sub-module wsb_addr_gen holds the stream counter, wrap logic, remaining count and FSM. It outputs issue, row and last.
- The top level instantiates NUM_BANKS single_port_ram via generate. It also holds the 2-stage valid/row/last pipeline.

Test Plan:
- Load bank0 row5=pattern A and bank1 row5=pattern B, then rd_en rd_row=5 at cycle t -> q_valid=1 at t+2, q={B,A}, q_row=5.
- Stream start_row=40, num_rows=4, adv=1 -> q_row sequence 40, 41, 0, 1 on consecutive cycles. done coincides with row 1, busy falls the cycle after.
- Stream num_rows=3 with adv pattern 1,0,1,0,1 -> exactly 3 valids in order, gaps matching the adv lows, done on the third.
- ld_en during STREAM, and ld_en with ld_row=42 -> ld_err pulses each time, RAM unchanged (verify by readback).
- Reset asserted 1 cycle after start (num_rows=10) -> q_valid stays 0 after reset, busy=0, no done. A following rd_en still works.
- start with num_rows=0, and start+rd_en together in IDLE -> first: no busy, no valid. Second: stream only, index read dropped.
